// File: rtl/ibex_instr_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ibex_instr_resp_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    RESP  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/ibex_instr_resp_stats.sv
// Saturating grant / error-response counters for the instruction responder.
module ibex_instr_resp_stats
  import ibex_instr_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        grant_i,
  input  logic        err_resp_i,
  output logic [31:0] stat_grants_o,
  output logic [31:0] stat_errors_o
);

  logic [31:0] grants_q;
  logic [31:0] errors_q;

  // Count accepted requests and error responses, holding at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants_q <= '0;
      errors_q <= '0;
    end else begin
      if (grant_i && (grants_q != '1)) grants_q <= grants_q + 32'd1;
      if (err_resp_i && (errors_q != '1)) errors_q <= errors_q + 32'd1;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_errors_o = errors_q;

endmodule

// File: rtl/ibex_instr_responder.sv
// Instruction-fetch slave: grants requests after WaitStates stall cycles,
// returns one response per grant exactly one cycle later, reads a
// synchronous-read word memory and flags misaligned / out-of-range fetches.
// Optional statistics ports: define IBEX_INSTR_RESP_STATS_EN.
//
//   state | meaning
//   IDLE  | no request in flight, nothing to respond
//   STALL | request seen, counting down wait states before the grant
//   RESP  | response (rvalid) presented this cycle for last cycle's grant
module ibex_instr_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned MemWords   = 4096,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned WaitStates = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        busy_o
`ifdef IBEX_INSTR_RESP_STATS_EN
  ,
  output logic [31:0]                 stat_grants_o,
  output logic [31:0]                 stat_errors_o
`endif
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam logic [32:0] RANGE_LO = {1'b0, BaseAddr};
  localparam logic [32:0] MEM_SPAN = 33'(MemWords) * 33'(WORD_BYTES);
  localparam logic [3:0]  WS_LOAD  = 4'(WaitStates);
  localparam bit          NO_WAIT  = (WaitStates == 0);

  resp_state_e state_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        gnt_c;
  logic        addr_err_c;
  logic [32:0] offset_c;

  // Offset from the window base in 33 bits: addresses below the base wrap to
  // >= 2^32, which is never below the span, so one compare covers both ends.
  always_comb begin
    offset_c   = {1'b0, instr_addr_i} - RANGE_LO;
    addr_err_c = (offset_c[1:0] != 2'b00) || (offset_c >= MEM_SPAN);
  end

  // Grant decode; held off while reset is asserted.
  always_comb begin
    gnt_c = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        IDLE:    gnt_c = instr_req_i && NO_WAIT;
        STALL:   gnt_c = instr_req_i && (cnt_q <= 4'd1);
        RESP:    gnt_c = instr_req_i && NO_WAIT;
        default: gnt_c = 1'b0;
      endcase
    end
  end

  // Sequencing FSM; the cycle that first sees a request counts as the first
  // stall cycle, so cnt_q holds the stall cycles remaining including this one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          if (instr_req_i) begin
            if (NO_WAIT) begin
              state_q <= RESP;
              err_q   <= addr_err_c;
            end else begin
              state_q <= STALL;
              cnt_q   <= WS_LOAD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        STALL: begin
          if (!instr_req_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q <= 4'd1) begin
            state_q <= RESP;
            cnt_q   <= '0;
            err_q   <= addr_err_c;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state; read data passes straight from memory.
  always_comb begin
    instr_gnt_o    = gnt_c;
    mem_req_o      = gnt_c && !addr_err_c;
    mem_addr_o     = offset_c[AW+1:2];
    instr_rvalid_o = (state_q == RESP);
    instr_err_o    = (state_q == RESP) && err_q;
    instr_rdata_o  = ((state_q == RESP) && !err_q) ? mem_rdata_i : 32'h0;
    busy_o         = (state_q != IDLE);
  end

`ifdef IBEX_INSTR_RESP_STATS_EN
  ibex_instr_resp_stats u_stats (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .grant_i       (instr_gnt_o),
    .err_resp_i    (instr_err_o),
    .stat_grants_o (stat_grants_o),
    .stat_errors_o (stat_errors_o)
  );
`endif

endmodule
